// File: rtl/alu_xbar_pe.sv
// alu_xbar_pe
//   Single-ALU CGRA processing element.
//   - A 4x4 input crossbar picks each ALU operand and each memory-unit operand
//     from {in0, in1, registered ALU result, memory-unit result}.
//   - The ALU result is registered (1-cycle latency).
//   - A 2x1 output switch drives out0 from either the ALU register or mem_out.
//   - A 13-bit serial configuration chain, clocked by config_clk, holds the
//     opcode, the output select and the four crossbar selects.
//
// Ports
//   clk          datapath clock, rising edge
//   reset        async active-high, clears the ALU result register
//   config_clk   config-chain shift clock, rising edge
//   config_reset async active-high, clears the config chain
//   config_in    serial config input (enters at bit 12)
//   config_out   serial config output (bit 0)
//   in0, in1     PE data inputs
//   mem_out      result from the external memory unit
//   mem_in0      crossbar output 2, memory-unit operand 0
//   mem_in1      crossbar output 3, memory-unit operand 1
//   out0         PE output
//
// Config word layout: [12:9] opcode, [8] output select (1 = mem_out),
//   [2k+1:2k] crossbar select for output k (0=in0, 1=in1, 2=alu_q, 3=mem_out).
// There is no handshake: the datapath computes every clk, and the
// configuration is treated as quasi-static.

module alu_xbar_pe #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            config_clk,
  input  logic            config_reset,
  input  logic            config_in,
  output logic            config_out,
  input  logic [SIZE-1:0] in0,
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] mem_out,
  output logic [SIZE-1:0] mem_in0,
  output logic [SIZE-1:0] mem_in1,
  output logic [SIZE-1:0] out0
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_LSR  = 4'd7,
    OP_ASR  = 4'd8,
    OP_EQ   = 4'd9,
    OP_SLT  = 4'd10,
    OP_ULT  = 4'd11,
    OP_PASA = 4'd12,
    OP_PASB = 4'd13,
    OP_SMIN = 4'd14,
    OP_ZERO = 4'd15
  } op_e;

  // ---------------------------------------------------------------------
  // Configuration chain: shifts toward bit 0, so the first bit sent ends
  // up in bit 0 after 13 shifts.
  // ---------------------------------------------------------------------
  logic [12:0] cfg;

  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) begin
      cfg <= '0;
    end else begin
      cfg <= {config_in, cfg[12:1]};
    end
  end

  assign config_out = cfg[0];

  op_e        op;
  logic       osel;
  logic [1:0] isel0, isel1, isel2, isel3;

  assign op    = op_e'(cfg[12:9]);
  assign osel  = cfg[8];
  assign isel0 = cfg[1:0];
  assign isel1 = cfg[3:2];
  assign isel2 = cfg[5:4];
  assign isel3 = cfg[7:6];

  // ---------------------------------------------------------------------
  // Input crossbar. The alu_q source is a register output, so routing it
  // back to the operands never forms a combinational loop.
  // ---------------------------------------------------------------------
  logic [SIZE-1:0] alu_q;
  logic [SIZE-1:0] op_a, op_b;

  function automatic logic [SIZE-1:0] xbar_pick(
    input logic [1:0]      sel,
    input logic [SIZE-1:0] s0,
    input logic [SIZE-1:0] s1,
    input logic [SIZE-1:0] s2,
    input logic [SIZE-1:0] s3
  );
    logic [SIZE-1:0] r;
    case (sel)
      2'd0:    r = s0;
      2'd1:    r = s1;
      2'd2:    r = s2;
      default: r = s3;
    endcase
    return r;
  endfunction

  assign op_a    = xbar_pick(isel0, in0, in1, alu_q, mem_out);
  assign op_b    = xbar_pick(isel1, in0, in1, alu_q, mem_out);
  assign mem_in0 = xbar_pick(isel2, in0, in1, alu_q, mem_out);
  assign mem_in1 = xbar_pick(isel3, in0, in1, alu_q, mem_out);

  // ---------------------------------------------------------------------
  // ALU. Only the low five bits of B form the shift amount; compare
  // results are zero-extended.
  // ---------------------------------------------------------------------
  logic [SIZE-1:0] alu_d;
  logic [4:0]      shamt;
  logic            eq_f, slt_f, ult_f;

  assign shamt = op_b[4:0];
  assign eq_f  = (op_a == op_b);
  assign slt_f = ($signed(op_a) < $signed(op_b));
  assign ult_f = (op_a < op_b);

  always_comb begin
    alu_d = '0;
    case (op)
      OP_ADD:  alu_d = op_a + op_b;
      OP_SUB:  alu_d = op_a - op_b;
      OP_MUL:  alu_d = op_a * op_b;
      OP_AND:  alu_d = op_a & op_b;
      OP_OR:   alu_d = op_a | op_b;
      OP_XOR:  alu_d = op_a ^ op_b;
      OP_SHL:  alu_d = op_a << shamt;
      OP_LSR:  alu_d = op_a >> shamt;
      OP_ASR:  alu_d = $unsigned($signed(op_a) >>> shamt);
      OP_EQ:   alu_d = {{(SIZE-1){1'b0}}, eq_f};
      OP_SLT:  alu_d = {{(SIZE-1){1'b0}}, slt_f};
      OP_ULT:  alu_d = {{(SIZE-1){1'b0}}, ult_f};
      OP_PASA: alu_d = op_a;
      OP_PASB: alu_d = op_b;
      OP_SMIN: alu_d = slt_f ? op_a : op_b;
      OP_ZERO: alu_d = '0;
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q <= '0;
    end else begin
      alu_q <= alu_d;
    end
  end

  // Output switch.
  assign out0 = osel ? mem_out : alu_q;

endmodule

// File: tb/tb_alu_xbar_pe.sv
// Bench for alu_xbar_pe: directed vectors, expected values pushed into a
// queue by the stimulus and popped/compared by an independent monitor.

module tb_alu_xbar_pe;

  localparam int W = 32;

  // sel codes for which DUT output an expectation refers to
  localparam int S_OUT0 = 0;
  localparam int S_MI0  = 1;
  localparam int S_MI1  = 2;
  localparam int S_COUT = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         config_clk = 1'b0;
  logic         config_reset = 1'b1;
  logic         config_in = 1'b0;
  logic         config_out;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] mem_out = '0;
  logic [W-1:0] mem_in0;
  logic [W-1:0] mem_in1;
  logic [W-1:0] out0;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  int           sel_q[$];
  string        name_q[$];
  event         sample_ev;

  alu_xbar_pe #(.SIZE(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .config_clk   (config_clk),
    .config_reset (config_reset),
    .config_in    (config_in),
    .config_out   (config_out),
    .in0          (in0),
    .in1          (in1),
    .mem_out      (mem_out),
    .mem_in0      (mem_in0),
    .mem_in1      (mem_in1),
    .out0         (out0)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [12:0] mk_cfg(input logic [3:0] op, input logic osel,
                                         input logic [1:0] s3, input logic [1:0] s2,
                                         input logic [1:0] s1, input logic [1:0] s0);
    return {op, osel, s3, s2, s1, s0};
  endfunction

  task automatic shift_bit(input logic b);
    config_in = b;
    #2 config_clk = 1'b1;
    #2 config_clk = 1'b0;
  endtask

  // Bit 0 is sent first so it lands in CFG[0].
  task automatic load_cfg(input logic [12:0] v);
    for (int i = 0; i < 13; i++) shift_bit(v[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int sel, input logic [W-1:0] v, input string name);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(name);
    -> sample_ev;
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        int           s;
        string        n;
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        n = name_q.pop_front();
        case (s)
          S_OUT0:  a = out0;
          S_MI0:   a = mem_in0;
          S_MI1:   a = mem_in1;
          default: a = {{(W-1){1'b0}}, config_out};
        endcase
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: actual=0x%08h required=0x%08h", n, a, e);
        end
      end
    end
  end

  // ---------------- op sweep table ----------------
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
  } vec_t;

  vec_t vecs[] = '{
    '{4'd0,  32'hFFFFFFF0, 32'h4,  32'hFFFFFFF4},
    '{4'd1,  32'hFFFFFFF0, 32'h4,  32'hFFFFFFEC},
    '{4'd2,  32'hFFFFFFF0, 32'h4,  32'hFFFFFFC0},
    '{4'd3,  32'hFFFFFFF0, 32'h4,  32'h00000000},
    '{4'd4,  32'hFFFFFFF0, 32'h4,  32'hFFFFFFF4},
    '{4'd5,  32'hFFFFFFF0, 32'h5,  32'hFFFFFFF5},
    '{4'd6,  32'hFFFFFFF0, 32'h4,  32'hFFFFFF00},
    '{4'd6,  32'hFFFFFFF0, 32'h24, 32'hFFFFFF00},
    '{4'd7,  32'hFFFFFFF0, 32'h4,  32'h0FFFFFFF},
    '{4'd8,  32'hFFFFFFF0, 32'h4,  32'hFFFFFFFF},
    '{4'd9,  32'hFFFFFFF0, 32'h4,  32'h00000000},
    '{4'd9,  32'h00000007, 32'h7,  32'h00000001},
    '{4'd10, 32'hFFFFFFF0, 32'h4,  32'h00000001},
    '{4'd11, 32'hFFFFFFF0, 32'h4,  32'h00000000},
    '{4'd12, 32'hFFFFFFF0, 32'h4,  32'hFFFFFFF0},
    '{4'd13, 32'hFFFFFFF0, 32'h4,  32'h00000004},
    '{4'd14, 32'hFFFFFFF0, 32'h4,  32'hFFFFFFF0},
    '{4'd14, 32'h00000009, 32'h3,  32'h00000003},
    '{4'd15, 32'hFFFFFFF0, 32'h4,  32'h00000000}
  };

  // ---------------- stimulus ----------------
  initial begin
    logic [12:0] c_pass;
    logic [12:0] c_nxt;
    logic [12:0] c_add;

    // reset state
    #3;
    expect_val(S_OUT0, 32'h0, "reset_out0");
    expect_val(S_COUT, 32'h0, "reset_config_out");
    config_reset = 1'b0;
    tick();
    reset = 1'b0;

    // config load: A=in0, B=in1, ADD, ALU output
    c_add = mk_cfg(4'd0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0);
    load_cfg(c_add);
    in0 = 32'd5;
    in1 = 32'd7;
    tick();
    expect_val(S_OUT0, 32'd12, "cfg_load_add");

    // config_out replays the loaded word while the next word is shifted in
    c_nxt = mk_cfg(4'd12, 1'b0, 2'd1, 2'd0, 2'd1, 2'd0);
    for (int i = 0; i < 13; i++) begin
      expect_val(S_COUT, {{(W-1){1'b0}}, c_add[i]}, $sformatf("cfg_out_bit%0d", i));
      shift_bit(c_nxt[i]);
    end
    expect_val(S_COUT, {{(W-1){1'b0}}, c_nxt[0]}, "cfg_out_next_word");

    // reset with clk running; config must survive
    load_cfg(c_add);
    tick();
    expect_val(S_OUT0, 32'd12, "pre_reset");
    reset = 1'b1;
    #1;
    expect_val(S_OUT0, 32'h0, "reset_async");
    tick();
    tick();
    expect_val(S_OUT0, 32'h0, "reset_held");
    reset = 1'b0;
    tick();
    expect_val(S_OUT0, 32'd12, "cfg_kept_after_reset");

    // op sweep, A=in0 B=in1
    foreach (vecs[i]) begin
      c_pass = mk_cfg(vecs[i].op, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0);
      load_cfg(c_pass);
      in0 = vecs[i].a;
      in1 = vecs[i].b;
      tick();
      expect_val(S_OUT0, vecs[i].res, $sformatf("op%0d_vec%0d", vecs[i].op, i));
    end

    // accumulate: A=alu_q, B=in0
    load_cfg(mk_cfg(4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2));
    in0 = 32'd3;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    expect_val(S_OUT0, 32'd3, "acc_1");
    tick();
    expect_val(S_OUT0, 32'd6, "acc_2");
    tick();
    expect_val(S_OUT0, 32'd9, "acc_3");

    // memory routing, purely combinational
    load_cfg(mk_cfg(4'd0, 1'b1, 2'd3, 2'd1, 2'd0, 2'd0));
    in1 = 32'hA5;
    mem_out = 32'h5A;
    #1;
    expect_val(S_MI0, 32'hA5, "mem_in0_route");
    expect_val(S_MI1, 32'h5A, "mem_in1_route");
    expect_val(S_OUT0, 32'h5A, "out0_mem_sel");
    mem_out = 32'h33;
    #1;
    expect_val(S_OUT0, 32'h33, "out0_mem_comb");
    expect_val(S_MI1, 32'h33, "mem_in1_comb");

    // config_reset mid-run: all selects go to in0, ADD, ALU output
    in0 = 32'h10;
    tick();
    config_reset = 1'b1;
    #1;
    config_reset = 1'b0;
    expect_val(S_COUT, 32'h0, "cfg_reset_out");
    expect_val(S_MI0, 32'h10, "cfg_reset_mi0");
    expect_val(S_MI1, 32'h10, "cfg_reset_mi1");
    tick();
    expect_val(S_OUT0, 32'h20, "cfg_reset_2x");

    // drain and report
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
